alu_issue_stage: RTL and testbench
==================================

Name: alu_issue_stage

Overview:
ID/EX pipeline stage directly upstream of the ALU; registers decoded instruction fields and produces the ALU's op1, op2 and 4-bit sel.
- Decodes the main-control alu_op plus funct into sel; generates the immediate operand.
- Applies EX/MEM and MEM/WB forwarding at the output.
- Uses a valid/ready handshake with stall and flush.

Parameters:
WIDTH, 32, datapath width of operands and results
RA_W, 5, register address width
FWD_EN, 1, 1 = forwarding muxes active; 0 = operands taken from latched register data only

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
flush  input  1  synchronous squash of held and incoming entry
in_valid  input  1  decode stage presents an instruction
in_ready  output  1  stage can accept this cycle
rs_data  input  WIDTH  register-file read A
rt_data  input  WIDTH  register-file read B
rs_addr  input  RA_W  source A register number
rt_addr  input  RA_W  source B register number
rd_addr  input  RA_W  destination register number
imm  input  16  instruction immediate
alu_op  input  2  00 add, 01 sub, 10 R-type (use funct), 11 or-immediate
funct  input  6  R-type function field
alu_src  input  1  1 = op2 is extended immediate
reg_write_in  input  1  instruction writes rd
exmem_reg_write  input  1  EX/MEM will write back
exmem_rd  input  RA_W  EX/MEM destination
exmem_result  input  WIDTH  EX/MEM result
memwb_reg_write  input  1  MEM/WB will write back
memwb_rd  input  RA_W  MEM/WB destination
memwb_result  input  WIDTH  MEM/WB result
out_valid  output  1  op1/op2/sel valid for ALU
out_ready  input  1  downstream consumes this cycle
op1  output  WIDTH  ALU operand 1
op2  output  WIDTH  ALU operand 2
sel  output  4  ALU operation select
out_rd  output  RA_W  latched destination
out_reg_write  output  1  latched write enable, gated by out_valid
out_illegal  output  1  latched undefined-funct flag

Behaviour:
- Reset: out_valid=0, all latched fields=0, hence sel=0000, out_rd=0, out_reg_write=0, out_illegal=0. Reset wins over flush and capture. Reset mid-stall discards the held entry.
- in_ready = !out_valid || out_ready (combinational); reset and flush do not gate it.
- Capture on (in_valid && in_ready && !flush): latch rs/rt data and addrs, rd_addr, reg_write_in, alu_src, decoded sel, extended imm; out_valid<=1.
- Latency: the captured instruction appears on outputs in the next cycle.
- Consume without a new capture: out_valid<=0.
- Stall (out_valid && !out_ready): all latched fields hold. op1/op2 may still change via forwarding.
- Flush: out_valid<=0 next cycle, incoming instruction dropped regardless of in_valid/in_ready.
- Sel decode:
  - alu_op 00 -> 0010; alu_op 01 -> 0110; alu_op 11 -> 0001.
  - alu_op 10, funct: 100000->0010, 100010->0110, 100100->0000, 100101->0001, 101010->0111, 100111->1100.
  - Any other funct -> sel 0000, out_illegal=1.
- Immediate: zero-extended when alu_op=11, else sign-extended from imm[15].
- op1, combinational, priority order:
  1. exmem_result if FWD_EN && exmem_reg_write && exmem_rd==rs_q && rs_q!=0
  2. memwb_result under the same rule with memwb_*
  3. latched rs_data
- op2 = extended imm if alu_src_q, else forwarded rt value using the same rule on rt_q.
- EX/MEM beats MEM/WB when both match. Register 0 is never forwarded.
- out_reg_write = out_valid && reg_write_q.

Test Plan:
- Reset held 2 cycles, then released with in_valid=0 -> out_valid=0, sel=0000, out_reg_write=0.
- R-type capture, funct=100010, rs_data=9, rt_data=4, no forwarding, out_ready=1 -> next cycle out_valid=1, sel=0110, op1=9, op2=4; one cycle later out_valid=0.
- Forwarding priority: rs_addr=3, exmem_rd=3 (exmem_result=0x11), memwb_rd=3 (memwb_result=0x22), both write enables=1 -> op1=0x11. Drop exmem_reg_write -> op1=0x22. rs_addr=0 -> op1=rs_data.
- Immediate extension: alu_op=00, alu_src=1, imm=0xFFFC -> op2=0xFFFFFFFC, sel=0010. alu_op=11 with the same imm -> op2=0x0000FFFC, sel=0001.
- Stall then flush: capture A, out_ready=0 for 3 cycles -> fields stable, in_ready=0. Assert flush with in_valid=1 (B) -> next cycle out_valid=0 and B is not captured.
- Illegal funct: alu_op=10, funct=000011 -> sel=0000, out_illegal=1. Reset asserted during stall -> next cycle out_valid=0, out_illegal=0.

Source files
------------

// File: rtl/alu_issue_stage.sv
`default_nettype none
// ============================================================================
//  Module   : alu_issue_stage
//  Purpose  : ID/EX register in front of the ALU. Decodes the ALU select,
//             extends the immediate and forwards EX/MEM and MEM/WB results.
//  Revision : 1.0  initial release
// ============================================================================
module alu_issue_stage #(
    parameter int WIDTH  = 32,
    parameter int RA_W   = 5,
    parameter int FWD_EN = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic [RA_W-1:0]  rs_addr,
    input  logic [RA_W-1:0]  rt_addr,
    input  logic [RA_W-1:0]  rd_addr,
    input  logic [15:0]      imm,
    input  logic [1:0]       alu_op,
    input  logic [5:0]       funct,
    input  logic             alu_src,
    input  logic             reg_write_in,
    input  logic             exmem_reg_write,
    input  logic [RA_W-1:0]  exmem_rd,
    input  logic [WIDTH-1:0] exmem_result,
    input  logic             memwb_reg_write,
    input  logic [RA_W-1:0]  memwb_rd,
    input  logic [WIDTH-1:0] memwb_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] op1,
    output logic [WIDTH-1:0] op2,
    output logic [3:0]       sel,
    output logic [RA_W-1:0]  out_rd,
    output logic             out_reg_write,
    output logic             out_illegal
);

    localparam logic [3:0] c_SEL_AND = 4'b0000;
    localparam logic [3:0] c_SEL_OR  = 4'b0001;
    localparam logic [3:0] c_SEL_ADD = 4'b0010;
    localparam logic [3:0] c_SEL_SUB = 4'b0110;
    localparam logic [3:0] c_SEL_SLT = 4'b0111;
    localparam logic [3:0] c_SEL_NOR = 4'b1100;

    logic             r_valid;
    logic [WIDTH-1:0] r_rs_data;
    logic [WIDTH-1:0] r_rt_data;
    logic [RA_W-1:0]  r_rs_addr;
    logic [RA_W-1:0]  r_rt_addr;
    logic [RA_W-1:0]  r_rd;
    logic             r_reg_write;
    logic             r_alu_src;
    logic [3:0]       r_sel;
    logic             r_illegal;
    logic [WIDTH-1:0] r_imm_ext;

    logic [3:0]       w_sel;
    logic             w_illegal;
    logic [WIDTH-1:0] w_imm_ext;
    logic             w_capture;
    logic [WIDTH-1:0] w_rs_fwd;
    logic [WIDTH-1:0] w_rt_fwd;

    always_comb begin
        w_sel     = c_SEL_AND;
        w_illegal = 1'b0;
        case (alu_op)
            2'b00:   w_sel = c_SEL_ADD;
            2'b01:   w_sel = c_SEL_SUB;
            2'b11:   w_sel = c_SEL_OR;
            default: begin
                case (funct)
                    6'b100000: w_sel = c_SEL_ADD;
                    6'b100010: w_sel = c_SEL_SUB;
                    6'b100100: w_sel = c_SEL_AND;
                    6'b100101: w_sel = c_SEL_OR;
                    6'b101010: w_sel = c_SEL_SLT;
                    6'b100111: w_sel = c_SEL_NOR;
                    default:   w_illegal = 1'b1;
                endcase
            end
        endcase
    end

    // or-immediate is a logical op, so its immediate is zero-extended
    assign w_imm_ext = (alu_op == 2'b11) ? {{(WIDTH-16){1'b0}}, imm}
                                         : {{(WIDTH-16){imm[15]}}, imm};

    assign in_ready  = !r_valid || out_ready;
    assign w_capture = in_valid && in_ready && !flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid     <= 1'b0;
            r_rs_data   <= '0;
            r_rt_data   <= '0;
            r_rs_addr   <= '0;
            r_rt_addr   <= '0;
            r_rd        <= '0;
            r_reg_write <= 1'b0;
            r_alu_src   <= 1'b0;
            r_sel       <= '0;
            r_illegal   <= 1'b0;
            r_imm_ext   <= '0;
        end else if (w_capture) begin
            r_valid     <= 1'b1;
            r_rs_data   <= rs_data;
            r_rt_data   <= rt_data;
            r_rs_addr   <= rs_addr;
            r_rt_addr   <= rt_addr;
            r_rd        <= rd_addr;
            r_reg_write <= reg_write_in;
            r_alu_src   <= alu_src;
            r_sel       <= w_sel;
            r_illegal   <= w_illegal;
            r_imm_ext   <= w_imm_ext;
        end else if (flush || out_ready) begin
            r_valid     <= 1'b0;
        end
    end

    generate
        if (FWD_EN != 0) begin : g_fwd
            // EX/MEM is younger than MEM/WB, so it is checked first
            always_comb begin
                w_rs_fwd = r_rs_data;
                if (exmem_reg_write && (exmem_rd == r_rs_addr) && (r_rs_addr != '0))
                    w_rs_fwd = exmem_result;
                else if (memwb_reg_write && (memwb_rd == r_rs_addr) && (r_rs_addr != '0))
                    w_rs_fwd = memwb_result;

                w_rt_fwd = r_rt_data;
                if (exmem_reg_write && (exmem_rd == r_rt_addr) && (r_rt_addr != '0))
                    w_rt_fwd = exmem_result;
                else if (memwb_reg_write && (memwb_rd == r_rt_addr) && (r_rt_addr != '0))
                    w_rt_fwd = memwb_result;
            end
        end else begin : g_no_fwd
            assign w_rs_fwd = r_rs_data;
            assign w_rt_fwd = r_rt_data;
        end
    endgenerate

    assign out_valid     = r_valid;
    assign op1           = w_rs_fwd;
    assign op2           = r_alu_src ? r_imm_ext : w_rt_fwd;
    assign sel           = r_sel;
    assign out_rd        = r_rd;
    assign out_reg_write = r_valid && r_reg_write;
    assign out_illegal   = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_issue_stage
//  Purpose  : Scoreboard bench for alu_issue_stage.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_issue_stage;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [4:0]  rd_addr;
    logic [15:0] imm;
    logic [1:0]  alu_op;
    logic [5:0]  funct;
    logic        alu_src;
    logic        reg_write_in;
    logic        exmem_reg_write;
    logic [4:0]  exmem_rd;
    logic [31:0] exmem_result;
    logic        memwb_reg_write;
    logic [4:0]  memwb_rd;
    logic [31:0] memwb_result;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [3:0]  sel;
    logic [4:0]  out_rd;
    logic        out_reg_write;
    logic        out_illegal;

    alu_issue_stage #(.WIDTH(32), .RA_W(5), .FWD_EN(1)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .rs_data(rs_data), .rt_data(rt_data),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr),
        .imm(imm), .alu_op(alu_op), .funct(funct), .alu_src(alu_src),
        .reg_write_in(reg_write_in),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .out_valid(out_valid), .out_ready(out_ready),
        .op1(op1), .op2(op2), .sel(sel),
        .out_rd(out_rd), .out_reg_write(out_reg_write), .out_illegal(out_illegal)
    );

    typedef struct {
        logic [4:0]  rs, rt, rd;
        logic [31:0] rsd, rtd, immx;
        logic        src, rw, ill;
        logic [3:0]  sel;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] ref_sel(input logic [1:0] op, input logic [5:0] f);
        if (op == 2'b00) return 4'b0010;
        if (op == 2'b01) return 4'b0110;
        if (op == 2'b11) return 4'b0001;
        case (f)
            6'b100000: return 4'b0010;
            6'b100010: return 4'b0110;
            6'b100100: return 4'b0000;
            6'b100101: return 4'b0001;
            6'b101010: return 4'b0111;
            6'b100111: return 4'b1100;
            default:   return 4'b0000;
        endcase
    endfunction

    function automatic logic ref_ill(input logic [1:0] op, input logic [5:0] f);
        if (op != 2'b10) return 1'b0;
        return !(f inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100111});
    endfunction

    function automatic logic [31:0] fwd(input logic [4:0] a, input logic [31:0] d);
        if (a == 5'd0) return d;
        if (exmem_reg_write && exmem_rd == a) return exmem_result;
        if (memwb_reg_write && memwb_rd == a) return memwb_result;
        return d;
    endfunction

    task automatic issue(input logic [1:0] op, input logic [5:0] f, input logic [15:0] im,
                         input logic src, input logic [4:0] ra, input logic [4:0] rb,
                         input logic [4:0] rdd, input logic [31:0] da, input logic [31:0] db,
                         input logic rw);
        exp_t e;
        @(posedge clk); #2;
        in_valid = 1'b1; alu_op = op; funct = f; imm = im; alu_src = src;
        rs_addr = ra; rt_addr = rb; rd_addr = rdd; rs_data = da; rt_data = db;
        reg_write_in = rw;
        e.rs = ra; e.rt = rb; e.rd = rdd; e.rsd = da; e.rtd = db; e.src = src; e.rw = rw;
        e.immx = (op == 2'b11) ? {16'h0000, im} : {{16{im[15]}}, im};
        e.sel  = ref_sel(op, f);
        e.ill  = ref_ill(op, f);
        q.push_back(e);
    endtask

    // drops in_valid and returns after the monitor has seen the last output
    task automatic idle();
        @(posedge clk); #2;
        in_valid = 1'b0;
        @(negedge clk); #1;
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (!reset && out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_out", q.size(), 1);
            end else begin
                e = q.pop_front();
                chk("sb_sel", sel, e.sel);
                chk("sb_op1", op1, fwd(e.rs, e.rsd));
                chk("sb_op2", op2, e.src ? e.immx : fwd(e.rt, e.rtd));
                chk("sb_rd", out_rd, e.rd);
                chk("sb_rw", out_reg_write, e.rw);
                chk("sb_ill", out_illegal, e.ill);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stim
        exp_t dummy;
        logic [1:0]  t_op  [3];
        logic [15:0] t_imm [3];
        logic [5:0]  t_fn  [8];

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        rs_data = '0; rt_data = '0; rs_addr = '0; rt_addr = '0; rd_addr = '0;
        imm = '0; alu_op = '0; funct = '0; alu_src = 1'b0; reg_write_in = 1'b0;
        exmem_reg_write = 1'b0; exmem_rd = '0; exmem_result = '0;
        memwb_reg_write = 1'b0; memwb_rd = '0; memwb_result = '0;

        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_sel", sel, 0);
        chk("rst_rw", out_reg_write, 0);
        chk("rst_ill", out_illegal, 0);
        chk("rst_in_ready", in_ready, 1);

        // R-type subtract, then the stage drains
        issue(2'b10, 6'b100010, 16'h0000, 1'b0, 5'd1, 5'd2, 5'd5, 32'd9, 32'd4, 1'b1);
        idle();
        @(posedge clk); @(negedge clk);
        chk("drain_valid", out_valid, 0);
        chk("drain_rw", out_reg_write, 0);

        // forwarding priority
        exmem_reg_write = 1'b1; exmem_rd = 5'd3; exmem_result = 32'h11;
        memwb_reg_write = 1'b1; memwb_rd = 5'd3; memwb_result = 32'h22;
        issue(2'b00, 6'b0, 16'h0, 1'b0, 5'd3, 5'd4, 5'd6, 32'h55, 32'h66, 1'b1);
        idle();
        chk("fwd_exmem_op1", op1, 32'h11);
        exmem_reg_write = 1'b0;
        issue(2'b00, 6'b0, 16'h0, 1'b0, 5'd3, 5'd4, 5'd6, 32'h55, 32'h66, 1'b1);
        idle();
        exmem_reg_write = 1'b1; exmem_rd = 5'd0; memwb_rd = 5'd0;
        issue(2'b00, 6'b0, 16'h0, 1'b0, 5'd0, 5'd0, 5'd6, 32'h77, 32'h88, 1'b0);
        idle();
        exmem_rd = 5'd9; memwb_rd = 5'd7;
        issue(2'b01, 6'b0, 16'h0, 1'b0, 5'd8, 5'd7, 5'd2, 32'h99, 32'haa, 1'b1);
        idle();
        exmem_reg_write = 1'b0; memwb_reg_write = 1'b0;

        // immediate extension
        t_op[0] = 2'b00; t_imm[0] = 16'hFFFC;
        t_op[1] = 2'b11; t_imm[1] = 16'hFFFC;
        t_op[2] = 2'b01; t_imm[2] = 16'h7FF0;
        for (int i = 0; i < 3; i++)
            issue(t_op[i], 6'b0, t_imm[i], 1'b1, 5'd4, 5'd5, 5'd10, 32'h1, 32'h2, 1'b1);
        idle();

        // funct decode, back-to-back, including undefined codes
        t_fn[0] = 6'b100000; t_fn[1] = 6'b100010; t_fn[2] = 6'b100100; t_fn[3] = 6'b100101;
        t_fn[4] = 6'b101010; t_fn[5] = 6'b100111; t_fn[6] = 6'b000011; t_fn[7] = 6'b111111;
        for (int i = 0; i < 8; i++)
            issue(2'b10, t_fn[i], 16'h0, 1'b0, 5'(i + 1), 5'(i + 2), 5'(i + 11),
                  32'(i * 3), 32'(i * 7), i[0]);
        idle();

        // stall, forwarding during stall, then flush
        issue(2'b10, 6'b100101, 16'h0, 1'b0, 5'd10, 5'd11, 5'd12, 32'h1234, 32'h5678, 1'b1);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #2;
            in_valid = 1'b0;
            if (i == 1) begin
                exmem_reg_write = 1'b1; exmem_rd = 5'd10; exmem_result = 32'hABC;
            end
            @(negedge clk);
            chk("stall_valid", out_valid, 1);
            chk("stall_in_ready", in_ready, 0);
            chk("stall_sel", sel, q[0].sel);
            chk("stall_rd", out_rd, q[0].rd);
            chk("stall_op1", op1, fwd(q[0].rs, q[0].rsd));
            chk("stall_op2", op2, fwd(q[0].rt, q[0].rtd));
        end
        @(posedge clk); #2;
        flush = 1'b1; in_valid = 1'b1; rd_addr = 5'd20; alu_op = 2'b00;
        dummy = q.pop_front();
        @(posedge clk); #2;
        out_ready = 1'b1;
        @(negedge clk);
        chk("flush_valid", out_valid, 0);
        chk("flush_in_ready", in_ready, 1);
        @(posedge clk); #2;
        flush = 1'b0; in_valid = 1'b0; exmem_reg_write = 1'b0;
        @(negedge clk);
        chk("flush2_valid", out_valid, 0);

        // undefined funct held in a stall, then reset discards it
        issue(2'b10, 6'b000011, 16'h0, 1'b0, 5'd1, 5'd2, 5'd13, 32'h5, 32'h6, 1'b1);
        out_ready = 1'b0;
        @(posedge clk); #2;
        in_valid = 1'b0;
        @(negedge clk);
        chk("ill_valid", out_valid, 1);
        chk("ill_flag", out_illegal, 1);
        chk("ill_sel", sel, 0);
        chk("ill_rw", out_reg_write, 1);
        @(posedge clk); #2;
        reset = 1'b1;
        dummy = q.pop_front();
        @(posedge clk); #2;
        reset = 1'b0;
        @(negedge clk);
        chk("rst2_valid", out_valid, 0);
        chk("rst2_ill", out_illegal, 0);
        chk("rst2_rd", out_rd, 0);
        chk("rst2_sel", sel, 0);
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);

        chk("sb_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
